// File: rtl/semaforo_cruzamento_ctrl.sv
// Two-approach intersection controller with internal phase timers and latched car requests.
// Optional night flash mode is built in when SEMAFORO_PISCA_EN is defined.
module semaforo_cruzamento_ctrl #(
  parameter int T_GRN_MIN = 4,
  parameter int T_GRN_MAX = 8,
  parameter int T_YLW     = 2,
  parameter int T_ALLRED  = 1,
  parameter int CNT_W     = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CAR_A,
  input  logic       CAR_B,
`ifdef SEMAFORO_PISCA_EN
  input  logic       noturno,
`endif
  output logic       red_a,
  output logic       ylw_a,
  output logic       grn_a,
  output logic       red_b,
  output logic       ylw_b,
  output logic       grn_b,
  output logic [2:0] fase
);

  typedef enum logic [2:0] {
    GRN_A   = 3'd0,
    YLW_A   = 3'd1,
    VERM_AB = 3'd2,
    GRN_B   = 3'd3,
    YLW_B   = 3'd4,
    VERM_BA = 3'd5
`ifdef SEMAFORO_PISCA_EN
    , PISCA = 3'd6
`endif
  } state_t;

  localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(T_GRN_MIN - 1);
  localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(T_GRN_MAX - 1);
  localparam logic [CNT_W-1:0] C_YLW  = CNT_W'(T_YLW - 1);
  localparam logic [CNT_W-1:0] C_ALLR = CNT_W'(T_ALLRED - 1);

  state_t           state_r, state_nxt, base_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             pend_a_r, pend_b_r, pend_a_nxt, pend_b_nxt;
  logic             blink_r, blink_nxt;
  logic             req_a, req_b, green_s;

  // Phase sequencing: green yields early only when the own side is idle, otherwise at the max timer.
  always_comb begin
    req_a    = pend_a_r | CAR_A;
    req_b    = pend_b_r | CAR_B;
    base_nxt = GRN_A;
    case (state_r)
      GRN_A:   if (((cnt_r >= C_GMIN) && req_b && !CAR_A) || ((cnt_r == C_GMAX) && req_b)) base_nxt = YLW_A;
               else base_nxt = GRN_A;
      YLW_A:   if (cnt_r == C_YLW) base_nxt = VERM_AB; else base_nxt = YLW_A;
      VERM_AB: if (cnt_r == C_ALLR) base_nxt = GRN_B; else base_nxt = VERM_AB;
      GRN_B:   if (((cnt_r >= C_GMIN) && req_a && !CAR_B) || ((cnt_r == C_GMAX) && req_a)) base_nxt = YLW_B;
               else base_nxt = GRN_B;
      YLW_B:   if (cnt_r == C_YLW) base_nxt = VERM_BA; else base_nxt = YLW_B;
      VERM_BA: if (cnt_r == C_ALLR) base_nxt = GRN_A; else base_nxt = VERM_BA;
`ifdef SEMAFORO_PISCA_EN
      PISCA:   base_nxt = VERM_BA;
`endif
      default: base_nxt = GRN_A;
    endcase
`ifdef SEMAFORO_PISCA_EN
    state_nxt = noturno ? PISCA : base_nxt;
`else
    state_nxt = base_nxt;
`endif
  end

  // Phase timer, request latches and blink phase for the next edge.
  always_comb begin
    green_s = (state_r == GRN_A) || (state_r == GRN_B);
    if (state_nxt != state_r) cnt_nxt = {CNT_W{1'b0}};
    else if (green_s && (cnt_r == C_GMAX)) cnt_nxt = cnt_r;
`ifdef SEMAFORO_PISCA_EN
    else if ((state_r == PISCA) && (cnt_r == C_YLW)) cnt_nxt = {CNT_W{1'b0}};
`endif
    else cnt_nxt = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Clearing on entry to own green has priority over a same-cycle sensor hit.
    if ((state_nxt == GRN_A) && (state_r != GRN_A)) pend_a_nxt = 1'b0;
`ifdef SEMAFORO_PISCA_EN
    else if (state_nxt == PISCA) pend_a_nxt = 1'b0;
`endif
    else if (CAR_A && (state_r != GRN_A)) pend_a_nxt = 1'b1;
    else pend_a_nxt = pend_a_r;

    if ((state_nxt == GRN_B) && (state_r != GRN_B)) pend_b_nxt = 1'b0;
`ifdef SEMAFORO_PISCA_EN
    else if (state_nxt == PISCA) pend_b_nxt = 1'b0;
`endif
    else if (CAR_B && (state_r != GRN_B)) pend_b_nxt = 1'b1;
    else pend_b_nxt = pend_b_r;

`ifdef SEMAFORO_PISCA_EN
    if ((state_nxt == PISCA) && (state_r != PISCA)) blink_nxt = 1'b1;
    else if ((state_r == PISCA) && (cnt_r == C_YLW)) blink_nxt = ~blink_r;
    else blink_nxt = blink_r;
`else
    blink_nxt = 1'b1;
`endif
  end

  // State, timer and request registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r  <= GRN_A;
      cnt_r    <= {CNT_W{1'b0}};
      pend_a_r <= 1'b0;
      pend_b_r <= 1'b0;
      blink_r  <= 1'b1;
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      pend_a_r <= pend_a_nxt;
      pend_b_r <= pend_b_nxt;
      blink_r  <= blink_nxt;
    end
  end

  // Moore lamp decode; unknown codes show all-red until the next edge recovers.
  always_comb begin
    red_a = 1'b0; ylw_a = 1'b0; grn_a = 1'b0;
    red_b = 1'b0; ylw_b = 1'b0; grn_b = 1'b0;
    fase  = state_r;
    case (state_r)
      GRN_A:   begin grn_a = 1'b1; red_b = 1'b1; end
      YLW_A:   begin ylw_a = 1'b1; red_b = 1'b1; end
      VERM_AB: begin red_a = 1'b1; red_b = 1'b1; end
      GRN_B:   begin red_a = 1'b1; grn_b = 1'b1; end
      YLW_B:   begin red_a = 1'b1; ylw_b = 1'b1; end
      VERM_BA: begin red_a = 1'b1; red_b = 1'b1; end
`ifdef SEMAFORO_PISCA_EN
      PISCA:   begin ylw_a = blink_r; ylw_b = blink_r; end
`endif
      default: begin red_a = 1'b1; red_b = 1'b1; end
    endcase
  end

endmodule
